inst_fetch_bridge: RTL and testbench

//  Parametrised instruction-fetch bridge between the openmips instruction port (ce/addr/inst) and a

---
 rtl/inst_fetch_bridge.sv | 160 ++++++++++++++++
 tb/tb_inst_fetch_bridge.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_bridge.sv
// Instruction-fetch bridge: a sequential prefetch FIFO between the core fetch port and a
// req/ack instruction memory. The core is stalled on misses, and redirects flush the FIFO.
module inst_fetch_bridge #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 4,
    parameter int ADDR_STEP = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_ce_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic              cpu_hold_i,
    output logic [DATA_W-1:0] cpu_inst_o,
    output logic              cpu_stall_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_data_i
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(ADDR_STEP);
    localparam logic [CW-1:0]     DEPTH_C = CW'(DEPTH);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_REQ = 1'b1} state_t;

    state_t            state_r, state_s;
    logic [ADDR_W-1:0] buf_addr_r [DEPTH];
    logic [DATA_W-1:0] buf_data_r [DEPTH];
    logic [PW-1:0]     head_r, head_s, wr_idx_s;
    logic [CW-1:0]     count_r, count_s;
    logic [ADDR_W-1:0] fetch_ptr_r, fetch_ptr_s, ptr_base_s;
    logic [ADDR_W-1:0] mem_addr_r, mem_addr_s;
    logic              ptr_valid_r, ptr_valid_s;
    logic              discard_r, discard_s;
    logic              hit_s, pop_s, flush_s, ack_s, same_s, push_s, can_issue_s;

    assign mem_req_o  = (state_r == ST_REQ);
    assign mem_addr_o = mem_addr_r;

    // Head-of-FIFO hit detection and the combinational core-facing outputs
    always_comb begin
        hit_s       = cpu_ce_i && (count_r != CW'(0)) && (buf_addr_r[head_r] == cpu_addr_i);
        cpu_inst_o  = {DATA_W{1'b0}};
        cpu_stall_o = 1'b0;
        if (!rst) begin
            cpu_inst_o  = {DATA_W{1'b0}};
            cpu_stall_o = 1'b0;
        end else if (hit_s) begin
            cpu_inst_o  = buf_data_r[head_r];
            cpu_stall_o = 1'b0;
        end else begin
            cpu_inst_o  = {DATA_W{1'b0}};
            cpu_stall_o = cpu_ce_i;
        end
    end

    // FIFO bookkeeping, fetch pointer and request FSM next-state
    always_comb begin
        ack_s   = (state_r == ST_REQ) && mem_ack_i;
        same_s  = (state_r == ST_REQ) && (mem_addr_r == cpu_addr_i);
        flush_s = cpu_ce_i && !hit_s;
        pop_s   = hit_s && !cpu_hold_i;
        head_s      = head_r;
        count_s     = count_r;
        ptr_base_s  = fetch_ptr_r;
        ptr_valid_s = ptr_valid_r;
        state_s     = state_r;
        mem_addr_s  = mem_addr_r;
        fetch_ptr_s = fetch_ptr_r;
        // A redirect keeps the in-flight word only when it is exactly the new target
        if (flush_s) begin
            push_s = ack_s && same_s;
        end else begin
            push_s = ack_s && !discard_r;
        end
        if (flush_s) begin
            count_s     = CW'(0);
            ptr_base_s  = same_s ? (cpu_addr_i + STEP) : cpu_addr_i;
            ptr_valid_s = 1'b1;
        end else if (pop_s) begin
            head_s  = head_r + PW'(1'b1);
            count_s = count_r - CW'(1'b1);
        end else begin
            count_s = count_r;
        end
        wr_idx_s = head_s + count_s[PW-1:0];
        if (push_s) begin
            count_s = count_s + CW'(1'b1);
        end else begin
            count_s = count_s;
        end
        if (ack_s) begin
            discard_s = 1'b0;
        end else if (flush_s && (state_r == ST_REQ)) begin
            discard_s = !same_s;
        end else begin
            discard_s = discard_r;
        end
        can_issue_s = ptr_valid_s && (count_s < DEPTH_C);
        case (state_r)
            ST_IDLE, ST_REQ: begin
                if (((state_r == ST_IDLE) || ack_s) && can_issue_s) begin
                    state_s     = ST_REQ;
                    mem_addr_s  = ptr_base_s;
                    fetch_ptr_s = ptr_base_s + STEP;
                end else if (ack_s) begin
                    state_s     = ST_IDLE;
                    fetch_ptr_s = ptr_base_s;
                end else begin
                    state_s     = state_r;
                    fetch_ptr_s = ptr_base_s;
                end
            end
            default: begin
                state_s     = ST_IDLE;
                fetch_ptr_s = ptr_base_s;
            end
        endcase
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            head_r      <= {PW{1'b0}};
            count_r     <= {CW{1'b0}};
            fetch_ptr_r <= {ADDR_W{1'b0}};
            mem_addr_r  <= {ADDR_W{1'b0}};
            ptr_valid_r <= 1'b0;
            discard_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            head_r      <= head_s;
            count_r     <= count_s;
            fetch_ptr_r <= fetch_ptr_s;
            mem_addr_r  <= mem_addr_s;
            ptr_valid_r <= ptr_valid_s;
            discard_r   <= discard_s;
        end
    end

    // Prefetch FIFO storage
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_addr_r[i] <= {ADDR_W{1'b0}};
                buf_data_r[i] <= {DATA_W{1'b0}};
            end
        end else if (push_s) begin
            buf_addr_r[wr_idx_s] <= mem_addr_r;
            buf_data_r[wr_idx_s] <= mem_data_i;
        end else begin
            buf_addr_r[wr_idx_s] <= buf_addr_r[wr_idx_s];
        end
    end

endmodule

// File: tb/tb_inst_fetch_bridge.sv
// Directed bench for inst_fetch_bridge: cycle table for the sequential stream plus
// hand-written redirect, hold, wrap, reset and small-depth sequences.
module tb_inst_fetch_bridge;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        ce, hold, stall, mreq, mack;
    logic [31:0] pc, inst, maddr, mdata;
    logic        ce2, hold2, stall2, mreq2, mack2;
    logic [31:0] pc2, inst2, maddr2, mdata2;

    int   checks = 0;
    int   errors = 0;
    int   lat1 = 2;
    int   mcnt1 = 0;
    int   mcnt2 = 0;
    logic force_ack1 = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    inst_fetch_bridge dut (
        .clk(clk), .rst(rst), .cpu_ce_i(ce), .cpu_addr_i(pc), .cpu_hold_i(hold),
        .cpu_inst_o(inst), .cpu_stall_o(stall), .mem_req_o(mreq), .mem_addr_o(maddr),
        .mem_ack_i(mack), .mem_data_i(mdata)
    );

    inst_fetch_bridge #(.DEPTH(2)) dut2 (
        .clk(clk), .rst(rst), .cpu_ce_i(ce2), .cpu_addr_i(pc2), .cpu_hold_i(hold2),
        .cpu_inst_o(inst2), .cpu_stall_o(stall2), .mem_req_o(mreq2), .mem_addr_o(maddr2),
        .mem_ack_i(mack2), .mem_data_i(mdata2)
    );

    // Memory models: ack on the lat-th cycle of a held request
    assign mdata  = mem_word(maddr);
    assign mack   = (mreq && (mcnt1 == lat1 - 1)) || force_ack1;
    assign mdata2 = mem_word(maddr2);
    assign mack2  = mreq2 && (mcnt2 == 1);

    always @(posedge clk) begin
        if (mreq && !mack) mcnt1 <= mcnt1 + 1;
        else mcnt1 <= 0;
        if (mreq2 && !mack2) mcnt2 <= mcnt2 + 1;
        else mcnt2 <= 0;
    end

    typedef struct {
        logic        ce;
        logic [31:0] pc;
        logic        hold;
        logic        stall;
        logic [31:0] inst;
        logic        req;
        logic [31:0] addr;
    } vec_t;

    vec_t vecs [23];

    function automatic vec_t mkv(input logic c, input logic [31:0] p, input logic h,
                                 input logic s, input logic r, input logic [31:0] a);
        vec_t v;
        v.ce = c; v.pc = p; v.hold = h; v.stall = s; v.req = r; v.addr = a;
        v.inst = (c && !s) ? mem_word(p) : 32'h0;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic c, input logic [31:0] p, input logic h);
        @(posedge clk);
        #1;
        ce = c; pc = p; hold = h;
    endtask

    task automatic wait_hit(input string name, input int bound);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            @(negedge clk);
            if (!stall) ok = 1'b1;
        end
        chk(name, {31'b0, ok}, 32'd1);
    endtask

    task automatic reset_dut();
        ce = 1'b0; hold = 1'b0; pc = 32'h0; ce2 = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] log_a [4];
        int          nlog;
        int          acks;
        bit          ok;

        rst = 1'b0; ce = 1'b0; pc = 32'h0; hold = 1'b0;
        ce2 = 1'b0; pc2 = 32'h0; hold2 = 1'b0;
        #2;
        chk("rst_stall", {31'b0, stall}, 32'd0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_req", {31'b0, mreq}, 32'd0);
        chk("rst_addr", maddr, 32'h0);

        // Sequential stream, memory latency 2, then idle prefetch and zero-stall hits
        vecs[0]  = mkv(1'b1, 32'h00, 1'b0, 1'b1, 1'b0, 32'h00);
        vecs[1]  = mkv(1'b1, 32'h00, 1'b0, 1'b1, 1'b1, 32'h00);
        vecs[2]  = mkv(1'b1, 32'h00, 1'b0, 1'b1, 1'b1, 32'h00);
        vecs[3]  = mkv(1'b1, 32'h00, 1'b0, 1'b0, 1'b1, 32'h04);
        vecs[4]  = mkv(1'b1, 32'h04, 1'b0, 1'b1, 1'b1, 32'h04);
        vecs[5]  = mkv(1'b1, 32'h04, 1'b0, 1'b0, 1'b1, 32'h08);
        vecs[6]  = mkv(1'b1, 32'h08, 1'b0, 1'b1, 1'b1, 32'h08);
        vecs[7]  = mkv(1'b1, 32'h08, 1'b0, 1'b0, 1'b1, 32'h0C);
        vecs[8]  = mkv(1'b1, 32'h0C, 1'b0, 1'b1, 1'b1, 32'h0C);
        vecs[9]  = mkv(1'b1, 32'h0C, 1'b0, 1'b0, 1'b1, 32'h10);
        vecs[10] = mkv(1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 32'h10);
        vecs[11] = mkv(1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 32'h14);
        vecs[12] = mkv(1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 32'h14);
        vecs[13] = mkv(1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 32'h18);
        vecs[14] = mkv(1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 32'h18);
        vecs[15] = mkv(1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 32'h1C);
        vecs[16] = mkv(1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 32'h1C);
        vecs[17] = mkv(1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 32'h1C);
        vecs[18] = mkv(1'b1, 32'h14, 1'b0, 1'b0, 1'b1, 32'h20);
        vecs[19] = mkv(1'b1, 32'h18, 1'b0, 1'b0, 1'b1, 32'h20);
        vecs[20] = mkv(1'b1, 32'h1C, 1'b0, 1'b0, 1'b1, 32'h24);
        vecs[21] = mkv(1'b1, 32'h20, 1'b0, 1'b0, 1'b1, 32'h24);
        vecs[22] = mkv(1'b1, 32'h24, 1'b0, 1'b0, 1'b1, 32'h28);

        @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 23; i++) begin
            drive(vecs[i].ce, vecs[i].pc, vecs[i].hold);
            @(negedge clk);
            chk($sformatf("vec%0d_stall", i), {31'b0, stall}, {31'b0, vecs[i].stall});
            chk($sformatf("vec%0d_inst", i), inst, vecs[i].inst);
            chk($sformatf("vec%0d_req", i), {31'b0, mreq}, {31'b0, vecs[i].req});
            chk($sformatf("vec%0d_addr", i), maddr, vecs[i].addr);
        end

        // Redirect while a prefetch is in flight: its data is dropped, 0x100 fetched next
        reset_dut();
        lat1 = 4;
        drive(1'b1, 32'h0, 1'b1);
        wait_hit("t2_first_hit", 30);
        drive(1'b0, 32'h0, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (mreq && maddr == 32'h0C) ok = 1'b1;
        end
        chk("t2_req_0c", {31'b0, ok}, 32'd1);
        drive(1'b1, 32'h100, 1'b0);
        @(negedge clk);
        chk("t2_stall", {31'b0, stall}, 32'd1);
        chk("t2_inst_zero", inst, 32'h0);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (mreq && maddr != 32'h0C) ok = 1'b1;
        end
        chk("t2_next_req", ok ? maddr : 32'hFFFF_FFFF, 32'h100);
        wait_hit("t2_hit_100", 20);
        chk("t2_inst_100", inst, mem_word(32'h100));
        drive(1'b1, 32'h104, 1'b0);
        wait_hit("t2_hit_104", 20);
        chk("t2_inst_104", inst, mem_word(32'h104));

        // Hold on a hit keeps the head; release pops exactly once
        reset_dut();
        lat1 = 2;
        drive(1'b1, 32'h0, 1'b1);
        wait_hit("t3_first_hit", 20);
        for (int i = 0; i < 10; i++) drive(1'b0, 32'h0, 1'b0);
        drive(1'b1, 32'h0, 1'b0);
        @(negedge clk);
        chk("t3_inst_0", inst, mem_word(32'h0));
        drive(1'b1, 32'h4, 1'b0);
        @(negedge clk);
        chk("t3_inst_4", inst, mem_word(32'h4));
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h8, 1'b1);
            @(negedge clk);
            chk($sformatf("t3_hold%0d_stall", i), {31'b0, stall}, 32'd0);
            chk($sformatf("t3_hold%0d_inst", i), inst, mem_word(32'h8));
        end
        drive(1'b1, 32'h8, 1'b0);
        @(negedge clk);
        chk("t3_release_stall", {31'b0, stall}, 32'd0);
        chk("t3_release_inst", inst, mem_word(32'h8));
        drive(1'b1, 32'hC, 1'b0);
        @(negedge clk);
        chk("t3_after_stall", {31'b0, stall}, 32'd0);
        chk("t3_after_inst", inst, mem_word(32'hC));
        drive(1'b1, 32'h10, 1'b0);
        @(negedge clk);
        chk("t3_next_inst", inst, mem_word(32'h10));

        // Address wrap at the top of the space
        reset_dut();
        drive(1'b1, 32'hFFFF_FFF8, 1'b1);
        nlog = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (mreq && mack && nlog < 4) begin
                log_a[nlog] = maddr;
                nlog++;
            end
        end
        chk("t4_nreq", (nlog >= 3) ? 32'd1 : 32'd0, 32'd1);
        chk("t4_req0", log_a[0], 32'hFFFF_FFF8);
        chk("t4_req1", log_a[1], 32'hFFFF_FFFC);
        chk("t4_req2", log_a[2], 32'h0000_0000);
        chk("t4_inst", inst, mem_word(32'hFFFF_FFF8));

        // Asynchronous reset in the middle of a request, late ack afterwards
        reset_dut();
        lat1 = 20;
        drive(1'b1, 32'h40, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 5 && !ok; i++) begin
            @(negedge clk);
            if (mreq) ok = 1'b1;
        end
        chk("t5_req_up", {31'b0, ok}, 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("t5_req_zero", {31'b0, mreq}, 32'd0);
        chk("t5_addr_zero", maddr, 32'h0);
        chk("t5_stall_zero", {31'b0, stall}, 32'd0);
        chk("t5_inst_zero", inst, 32'h0);
        ce = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        force_ack1 = 1'b1;
        lat1 = 2;
        @(posedge clk);
        #1 force_ack1 = 1'b0;
        @(negedge clk);
        chk("t5_no_req", {31'b0, mreq}, 32'd0);
        drive(1'b1, 32'h80, 1'b1);
        ok = 1'b0;
        for (int i = 0; i < 5 && !ok; i++) begin
            @(negedge clk);
            if (mreq) ok = 1'b1;
        end
        chk("t5_restart_addr", ok ? maddr : 32'hFFFF_FFFF, 32'h80);
        wait_hit("t5_hit", 20);
        chk("t5_inst", inst, mem_word(32'h80));

        // DEPTH=2 instance: prefetch stops at two entries until a pop
        @(posedge clk);
        #1 ce2 = 1'b1; pc2 = 32'h0; hold2 = 1'b0;
        @(posedge clk);
        #1 ce2 = 1'b0;
        acks = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mreq2 && mack2) acks++;
        end
        chk("t6_acks", acks, 32'd2);
        chk("t6_req_idle", {31'b0, mreq2}, 32'd0);
        @(posedge clk);
        #1 ce2 = 1'b1; pc2 = 32'h0;
        @(negedge clk);
        chk("t6_hit_stall", {31'b0, stall2}, 32'd0);
        chk("t6_hit_inst", inst2, mem_word(32'h0));
        @(posedge clk);
        #1 ce2 = 1'b0;
        @(negedge clk);
        chk("t6_req_after_pop", {31'b0, mreq2}, 32'd1);
        chk("t6_addr_after_pop", maddr2, 32'h8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
